// File: rtl/tt_vfp_pkg.sv
// Shared types and encodings for the vector FP element sequencer.
// Element widths here describe the default half-precision configuration.
package tt_vfp_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  localparam logic [1:0] MODE_CVT = 2'd0;
  localparam logic [1:0] MODE_ADD = 2'd1;
  localparam logic [1:0] MODE_MUL = 2'd2;
  localparam logic [1:0] MODE_FMA = 2'd3;

  localparam logic [1:0] FMA_MADD  = 2'd0;
  localparam logic [1:0] FMA_MSUB  = 2'd1;
  localparam logic [1:0] FMA_NMSUB = 2'd2;
  localparam logic [1:0] FMA_NMADD = 2'd3;

  localparam int EXP_W  = 5;
  localparam int SIG_W  = 11;
  localparam int IEEE_W = EXP_W + SIG_W;
  localparam int REC_W  = IEEE_W + 1;

  // Recoded NaN: exponent top bits 3'b111, quiet bit set.
  localparam logic [IEEE_W-1:0] CANON_NAN     = 16'h7E00;
  localparam logic [REC_W-1:0]  CANON_NAN_REC = 17'h0E200;

endpackage

// File: rtl/tt_vfp_lat_tracker.sv
// Tracks {valid, idx} of issued elements through a fixed DEPTH-cycle pipe; pop appears DEPTH cycles after push.
// No backpressure: pushed every cycle; any_valid reports occupancy after the current shift.
module tt_vfp_lat_tracker #(
  parameter int DEPTH = 3,
  parameter int IDXW  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_valid,
  input  logic [IDXW-1:0] push_idx,
  output logic            pop_valid,
  output logic [IDXW-1:0] pop_idx,
  output logic            any_valid
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [IDXW-1:0]  idx_q [DEPTH];

  generate
    if (DEPTH == 1) begin : g_one
      assign vld_d = push_valid;
    end else begin : g_many
      assign vld_d = {vld_q[DEPTH-2:0], push_valid};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else begin
      vld_q    <= vld_d;
      idx_q[0] <= push_idx;
      for (int i = 1; i < DEPTH; i++) idx_q[i] <= idx_q[i-1];
    end
  end

  assign pop_valid = vld_q[DEPTH-1];
  assign pop_idx   = idx_q[DEPTH-1];
  assign any_valid = |vld_d;

endmodule

// File: rtl/tt_vfp_elem_seq.sv
// Sequences one vector FP request into per-element FMA issues; response in cycle vl+FMA_LAT+1 after accept.
// One request in flight: o_req_ready only in IDLE; response held until i_rsp_ready.
module tt_vfp_elem_seq
  import tt_vfp_pkg::*;
#(
  parameter int expWidth = 5,
  parameter int sigWidth = 11,
  parameter int NELEM    = 8,
  parameter int FMA_LAT  = 3
) (
  input  logic                                i_clk,
  input  logic                                i_reset_n,
  input  logic                                i_req_valid,
  output logic                                o_req_ready,
  input  logic [1:0]                          i_req_mode,
  input  logic [1:0]                          i_req_fma_op,
  input  logic [2:0]                          i_req_rm,
  input  logic [$clog2(NELEM+1)-1:0]          i_req_vl,
  input  logic [NELEM-1:0]                    i_req_mask,
  input  logic [NELEM*(expWidth+sigWidth+1)-1:0] i_req_vs1,
  input  logic [NELEM*(expWidth+sigWidth+1)-1:0] i_req_vs2,
  input  logic [NELEM*(expWidth+sigWidth+1)-1:0] i_req_vs3,
  input  logic [NELEM*(expWidth+sigWidth)-1:0]   i_req_vd_old,
  output logic                                o_ex_valid,
  output logic [1:0]                          o_ex_mode,
  output logic [1:0]                          o_ex_fma_op,
  output logic [2:0]                          o_ex_rm,
  output logic [expWidth+sigWidth:0]          o_ex_a,
  output logic [expWidth+sigWidth:0]          o_ex_b,
  output logic [expWidth+sigWidth:0]          o_ex_c,
  input  logic [expWidth+sigWidth-1:0]        i_ex_res,
  input  logic [4:0]                          i_ex_exc,
  output logic                                o_rsp_valid,
  input  logic                                i_rsp_ready,
  output logic [NELEM*(expWidth+sigWidth)-1:0] o_rsp_vd,
  output logic [4:0]                          o_rsp_exc
);

  localparam int IEW  = expWidth + sigWidth;
  localparam int REW  = IEW + 1;
  localparam int VLW  = $clog2(NELEM + 1);
  localparam int IDXW = (NELEM > 1) ? $clog2(NELEM) : 1;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q;
  logic [VLW-1:0]   vl_q;
  logic [NELEM-1:0] mask_q;
  logic [1:0]       mode_q, fma_op_q;
  logic [2:0]       rm_q;
  logic [4:0]       exc_q;
  logic [REW-1:0]   vs1_q [NELEM];
  logic [REW-1:0]   vs2_q [NELEM];
  logic [REW-1:0]   vs3_q [NELEM];
  logic [IEW-1:0]   vd_q  [NELEM];

  logic             accept, last;
  logic [VLW-1:0]   vl_clamped;
  logic             pop_valid, any_valid;
  logic [IDXW-1:0]  pop_idx;

  assign o_req_ready = (state_q == IDLE);
  assign accept      = i_req_valid && o_req_ready;
  assign vl_clamped  = (i_req_vl > VLW'(NELEM)) ? VLW'(NELEM) : i_req_vl;
  assign last        = ((VLW'(idx_q) + VLW'(1)) == vl_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (vl_clamped == '0) ? RESP : ISSUE;
      ISSUE:   if (last) state_d = DRAIN;
      DRAIN:   if (!any_valid) state_d = RESP;
      RESP:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Inactive or masked elements still take their slot but never reach the unit.
  assign o_ex_valid  = (state_q == ISSUE) && mask_q[idx_q] && (mode_q != MODE_CVT);
  assign o_ex_mode   = mode_q;
  assign o_ex_fma_op = fma_op_q;
  assign o_ex_rm     = rm_q;
  assign o_ex_a      = vs1_q[idx_q];
  assign o_ex_b      = vs2_q[idx_q];
  assign o_ex_c      = vs3_q[idx_q];

  tt_vfp_lat_tracker #(
    .DEPTH (FMA_LAT),
    .IDXW  (IDXW)
  ) u_tracker (
    .clk        (i_clk),
    .rst_n      (i_reset_n),
    .push_valid (o_ex_valid),
    .push_idx   (idx_q),
    .pop_valid  (pop_valid),
    .pop_idx    (pop_idx),
    .any_valid  (any_valid)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      vl_q     <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      fma_op_q <= '0;
      rm_q     <= '0;
      exc_q    <= '0;
      for (int k = 0; k < NELEM; k++) begin
        vs1_q[k] <= '0;
        vs2_q[k] <= '0;
        vs3_q[k] <= '0;
        vd_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q    <= '0;
        vl_q     <= vl_clamped;
        mask_q   <= i_req_mask;
        mode_q   <= i_req_mode;
        fma_op_q <= i_req_fma_op;
        rm_q     <= i_req_rm;
        exc_q    <= '0;
        for (int k = 0; k < NELEM; k++) begin
          vs1_q[k] <= i_req_vs1[k*REW +: REW];
          vs2_q[k] <= i_req_vs2[k*REW +: REW];
          vs3_q[k] <= i_req_vs3[k*REW +: REW];
          vd_q[k]  <= i_req_vd_old[k*IEW +: IEW];
        end
      end else begin
        if ((state_q == ISSUE) && !last) idx_q <= idx_q + IDXW'(1);
        if (pop_valid) begin
          vd_q[pop_idx] <= i_ex_res;
          exc_q         <= exc_q | i_ex_exc;
        end
      end
    end
  end

  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_exc   = exc_q;

  always_comb begin
    o_rsp_vd = '0;
    for (int k = 0; k < NELEM; k++) o_rsp_vd[k*IEW +: IEW] = vd_q[k];
  end

endmodule

// File: tb/tb_tt_vfp_elem_seq.sv
// Directed bench for tt_vfp_elem_seq with a table-driven FMA unit responder.
module tb_tt_vfp_elem_seq;

  localparam int EW  = 5;
  localparam int SW  = 11;
  localparam int NE  = 8;
  localparam int LAT = 3;
  localparam int IW  = EW + SW;
  localparam int RW  = IW + 1;
  localparam int VLW = 4;

  logic              i_clk, i_reset_n;
  logic              i_req_valid, o_req_ready;
  logic [1:0]        i_req_mode, i_req_fma_op;
  logic [2:0]        i_req_rm;
  logic [VLW-1:0]    i_req_vl;
  logic [NE-1:0]     i_req_mask;
  logic [NE*RW-1:0]  i_req_vs1, i_req_vs2, i_req_vs3;
  logic [NE*IW-1:0]  i_req_vd_old;
  logic              o_ex_valid;
  logic [1:0]        o_ex_mode, o_ex_fma_op;
  logic [2:0]        o_ex_rm;
  logic [RW-1:0]     o_ex_a, o_ex_b, o_ex_c;
  logic [IW-1:0]     i_ex_res;
  logic [4:0]        i_ex_exc;
  logic              o_rsp_valid, i_rsp_ready;
  logic [NE*IW-1:0]  o_rsp_vd;
  logic [4:0]        o_rsp_exc;

  tt_vfp_elem_seq #(
    .expWidth(EW), .sigWidth(SW), .NELEM(NE), .FMA_LAT(LAT)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_mode(i_req_mode), .i_req_fma_op(i_req_fma_op), .i_req_rm(i_req_rm),
    .i_req_vl(i_req_vl), .i_req_mask(i_req_mask),
    .i_req_vs1(i_req_vs1), .i_req_vs2(i_req_vs2), .i_req_vs3(i_req_vs3),
    .i_req_vd_old(i_req_vd_old),
    .o_ex_valid(o_ex_valid), .o_ex_mode(o_ex_mode), .o_ex_fma_op(o_ex_fma_op),
    .o_ex_rm(o_ex_rm), .o_ex_a(o_ex_a), .o_ex_b(o_ex_b), .o_ex_c(o_ex_c),
    .i_ex_res(i_ex_res), .i_ex_exc(i_ex_exc),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_vd(o_rsp_vd), .o_rsp_exc(o_rsp_exc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Half-precision to recoded form for normals, zero and infinity.
  function automatic logic [RW-1:0] rec(input logic [IW-1:0] h);
    logic [4:0] e;
    e = h[14:10];
    if (e == 5'd0)       return {h[15], 6'd0, h[9:0]};
    else if (e == 5'h1F) return {h[15], 3'b110, 3'b000, h[9:0]};
    else                 return {h[15], 6'(e) + 6'd17, h[9:0]};
  endfunction

  // Known results for the directed operand sets; anything else is a distinctive junk value.
  function automatic logic [20:0] ex_model(input logic [1:0] mode, input logic [1:0] op,
                                           input logic [RW-1:0] a, input logic [RW-1:0] b,
                                           input logic [RW-1:0] c);
    if (mode == 2'd1 && a == rec(16'h3C00) && c == rec(16'h4000)) return {16'h4200, 5'b00000};
    if (mode == 2'd3 && op == 2'd0 && a == rec(16'h4000) && b == rec(16'h4200) && c == rec(16'h3C00))
      return {16'h4700, 5'b00000};
    if (mode == 2'd2 && a == rec(16'h7BFF) && b == rec(16'h7BFF)) return {16'h7C00, 5'b00101};
    if (mode == 2'd2 && a == rec(16'h3C00) && b == rec(16'h4000)) return {16'h4000, 5'b00000};
    if (mode == 2'd2 && a == rec(16'h7BFF) && b == rec(16'h4000)) return {16'h7C00, 5'b00101};
    if (mode == 2'd2 && a == rec(16'h7C00) && b == rec(16'h0000)) return {16'h7E00, 5'b10000};
    return {16'hDEAD, 5'b01000};
  endfunction

  logic        pv [0:LAT];
  logic [20:0] pd [0:LAT];

  initial begin
    for (int j = 0; j <= LAT; j++) begin
      pv[j] = 1'b0;
      pd[j] = '0;
    end
  end

  // Execution unit stand-in: result for an element issued in cycle n is presented in cycle n+LAT.
  always @(negedge i_clk) begin
    for (int j = LAT; j > 0; j--) begin
      pv[j] = pv[j-1];
      pd[j] = pd[j-1];
    end
    pv[0] = o_ex_valid;
    pd[0] = ex_model(o_ex_mode, o_ex_fma_op, o_ex_a, o_ex_b, o_ex_c);
    i_ex_res = pv[LAT] ? pd[LAT][20:5] : 16'hBEEF;
    i_ex_exc = pv[LAT] ? pd[LAT][4:0]  : 5'h1F;
  end

  task automatic send(input logic [1:0] mode, input logic [1:0] op, input logic [2:0] rm,
                      input logic [VLW-1:0] vl, input logic [NE-1:0] mask,
                      input logic [NE*RW-1:0] v1, input logic [NE*RW-1:0] v2,
                      input logic [NE*RW-1:0] v3, input logic [NE*IW-1:0] old);
    i_req_mode = mode; i_req_fma_op = op; i_req_rm = rm; i_req_vl = vl; i_req_mask = mask;
    i_req_vs1 = v1; i_req_vs2 = v2; i_req_vs3 = v3; i_req_vd_old = old;
    i_req_valid = 1'b1;
  endtask

  int unsigned last_rm, last_op;

  // Counts cycles from the accept cycle (cycle 0) until o_rsp_valid, bounded.
  task automatic wait_rsp(output int cyc, output int pulses);
    cyc = 1;
    pulses = 0;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    while (!o_rsp_valid && cyc < 200) begin
      if (o_ex_valid) begin
        pulses++;
        last_rm = o_ex_rm;
        last_op = o_ex_fma_op;
      end
      @(posedge i_clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake();
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, pl;
    logic [NE*RW-1:0] v1, v2, v3;
    logic [NE*IW-1:0] old, expv;

    i_reset_n = 1'b0; i_req_valid = 1'b0; i_rsp_ready = 1'b0;
    i_req_mode = '0; i_req_fma_op = '0; i_req_rm = '0; i_req_vl = '0; i_req_mask = '0;
    i_req_vs1 = '0; i_req_vs2 = '0; i_req_vs3 = '0; i_req_vd_old = '0;
    last_rm = 0; last_op = 0;
    #2;
    chk("rst_ex_valid",  128'(o_ex_valid),  128'(0));
    chk("rst_rsp_valid", 128'(o_rsp_valid), 128'(0));
    chk("rst_rsp_exc",   128'(o_rsp_exc),   128'(0));
    chk("rst_rsp_vd",    128'(o_rsp_vd),    128'(0));
    chk("rst_req_ready", 128'(o_req_ready), 128'(1));
    @(negedge i_clk); i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    // add: 1.0 + 2.0 in element 0 only
    for (int k = 0; k < NE; k++) old[k*IW +: IW] = 16'h1000 + 16'(k);
    v1 = '0; v2 = '0; v3 = '0;
    v1[0 +: RW] = rec(16'h3C00); v2[0 +: RW] = rec(16'h3C00); v3[0 +: RW] = rec(16'h4000);
    send(2'd1, 2'd0, 3'd0, 4'd1, 8'h01, v1, v2, v3, old);
    wait_rsp(cyc, pl);
    expv = old; expv[0 +: IW] = 16'h4200;
    chk("add_cycle",  128'(cyc), 128'(5));
    chk("add_pulses", 128'(pl),  128'(1));
    chk("add_vd",     128'(o_rsp_vd),  128'(expv));
    chk("add_exc",    128'(o_rsp_exc), 128'(0));
    handshake();
    chk("add_after_rsp_valid", 128'(o_rsp_valid), 128'(0));
    chk("add_after_req_ready", 128'(o_req_ready), 128'(1));

    // madd 2*3+1 on all eight elements, RMM forwarded
    v1 = {NE{rec(16'h4000)}}; v2 = {NE{rec(16'h4200)}}; v3 = {NE{rec(16'h3C00)}};
    send(2'd3, 2'd0, 3'd4, 4'd8, 8'hFF, v1, v2, v3, old);
    wait_rsp(cyc, pl);
    chk("fma_cycle",  128'(cyc), 128'(12));
    chk("fma_pulses", 128'(pl),  128'(8));
    chk("fma_vd",     128'(o_rsp_vd),  {NE{16'h4700}});
    chk("fma_exc",    128'(o_rsp_exc), 128'(0));
    chk("fma_rm",     128'(last_rm),   128'(4));
    chk("fma_op",     128'(last_op),   128'(0));
    handshake();

    // vl above NELEM clamps to NELEM
    send(2'd3, 2'd0, 3'd0, 4'd13, 8'hFF, v1, v2, v3, old);
    wait_rsp(cyc, pl);
    chk("clamp_cycle",  128'(cyc), 128'(12));
    chk("clamp_pulses", 128'(pl),  128'(8));
    chk("clamp_vd",     128'(o_rsp_vd), {NE{16'h4700}});
    handshake();

    // masked mul: only elements 1 and 3 active; others would raise invalid
    old = {NE{16'hAAAA}};
    for (int k = 0; k < NE; k++) begin
      v1[k*RW +: RW] = rec(16'h7C00);
      v2[k*RW +: RW] = rec(16'h0000);
    end
    v1[1*RW +: RW] = rec(16'h3C00); v2[1*RW +: RW] = rec(16'h4000);
    v1[3*RW +: RW] = rec(16'h7BFF); v2[3*RW +: RW] = rec(16'h4000);
    v3 = '0;
    send(2'd2, 2'd0, 3'd0, 4'd4, 8'hFA, v1, v2, v3, old);
    wait_rsp(cyc, pl);
    expv = old; expv[1*IW +: IW] = 16'h4000; expv[3*IW +: IW] = 16'h7C00;
    chk("mask_cycle",  128'(cyc), 128'(8));
    chk("mask_pulses", 128'(pl),  128'(2));
    chk("mask_vd",     128'(o_rsp_vd),  128'(expv));
    chk("mask_exc",    128'(o_rsp_exc), 128'(5'b00101));
    handshake();

    // vl == 0 responds straight away with vd_old
    for (int k = 0; k < NE; k++) old[k*IW +: IW] = 16'h5000 + 16'(k);
    v1 = {NE{rec(16'h4000)}}; v2 = {NE{rec(16'h4200)}}; v3 = {NE{rec(16'h3C00)}};
    send(2'd3, 2'd0, 3'd0, 4'd0, 8'hFF, v1, v2, v3, old);
    wait_rsp(cyc, pl);
    chk("vl0_cycle",  128'(cyc), 128'(1));
    chk("vl0_pulses", 128'(pl),  128'(0));
    chk("vl0_vd",     128'(o_rsp_vd),  128'(old));
    chk("vl0_exc",    128'(o_rsp_exc), 128'(0));
    handshake();

    // mode 0 issues nothing
    send(2'd0, 2'd0, 3'd0, 4'd4, 8'hFF, v1, v2, v3, old);
    wait_rsp(cyc, pl);
    chk("mode0_pulses", 128'(pl), 128'(0));
    chk("mode0_vd",     128'(o_rsp_vd),  128'(old));
    chk("mode0_exc",    128'(o_rsp_exc), 128'(0));
    handshake();

    // overflow to +inf under RNE, then response stall
    v1 = '0; v2 = '0; v3 = '0;
    v1[0 +: RW] = rec(16'h7BFF); v2[0 +: RW] = rec(16'h7BFF);
    send(2'd2, 2'd0, 3'd0, 4'd1, 8'h01, v1, v2, v3, old);
    wait_rsp(cyc, pl);
    expv = old; expv[0 +: IW] = 16'h7C00;
    chk("ovf_cycle", 128'(cyc), 128'(5));
    chk("ovf_vd",    128'(o_rsp_vd),  128'(expv));
    chk("ovf_exc",   128'(o_rsp_exc), 128'(5'b00101));
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk); #1;
      chk("stall_rsp_valid", 128'(o_rsp_valid), 128'(1));
      chk("stall_vd",        128'(o_rsp_vd),    128'(expv));
      chk("stall_exc",       128'(o_rsp_exc),   128'(5'b00101));
      chk("stall_req_ready", 128'(o_req_ready), 128'(0));
    end
    handshake();

    // reset while the overflow result is still in flight
    send(2'd2, 2'd0, 3'd0, 4'd1, 8'h01, v1, v2, v3, old);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(posedge i_clk); #1;
    i_reset_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 128'(o_rsp_valid), 128'(0));
    chk("arst_req_ready", 128'(o_req_ready), 128'(1));
    chk("arst_ex_valid",  128'(o_ex_valid),  128'(0));
    chk("arst_rsp_vd",    128'(o_rsp_vd),    128'(0));
    @(negedge i_clk); i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    for (int k = 0; k < NE; k++) old[k*IW +: IW] = 16'h6000 + 16'(k);
    send(2'd3, 2'd0, 3'd0, 4'd0, 8'hFF, v1, v2, v3, old);
    wait_rsp(cyc, pl);
    @(posedge i_clk); #1;
    chk("stale_rsp_valid", 128'(o_rsp_valid), 128'(1));
    chk("stale_vd",        128'(o_rsp_vd),    128'(old));
    chk("stale_exc",       128'(o_rsp_exc),   128'(0));
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
